// File: rtl/alu_share_pkg.sv
// Shared types and constants for the round-robin shared-ALU arbiter:
// FSM state encoding, ALU function codes and default widths.
package alu_share_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_OP_W    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_NOT  = 3'b010;
    localparam logic [2:0] ALU_SHL  = 3'b011;
    localparam logic [2:0] ALU_SHR  = 3'b100;
    localparam logic [2:0] ALU_AND  = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_RSVD = 3'b111;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response and shared-ALU signal bundle for alu_share_arbiter.
// slave = arbiter side, master = requesters plus the external ALU.
interface alu_share_arbiter_if
    import alu_share_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int OP_W    = DEF_OP_W
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ*OP_W-1:0]   req_op;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [NUM_REQ-1:0]        rsp_ready;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_err;
    logic [DATA_W-1:0]         alu_a;
    logic [DATA_W-1:0]         alu_b;
    logic [OP_W-1:0]           alu_control;
    logic [DATA_W-1:0]         alu_result;
    logic                      busy;

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready, alu_result,
        output req_ready, rsp_valid, rsp_data, rsp_err, alu_a, alu_b, alu_control, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready, alu_result,
        input  req_ready, rsp_valid, rsp_data, rsp_err, alu_a, alu_b, alu_control, busy
    );
endinterface

// File: rtl/alu_rr_pick.sv
// Combinational rotate-priority picker: first set request at or above ptr_i,
// wrapping around; returns one-hot grant, its index and an any-valid flag.
module alu_rr_pick
    import alu_share_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IW      = $clog2(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IW-1:0]      idx_o,
    output logic               any_o
);

    // Walk offsets from farthest to nearest so the nearest set bit wins last.
    always_comb begin
        logic [IW-1:0] pos;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        pos   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos   = IW'((int'(ptr_i) + k) % NUM_REQ);
            idx_o = req_i[pos] ? pos : idx_o;
            any_o = any_o | req_i[pos];
        end
        gnt_o = any_o ? (NUM_REQ'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external ALU among NUM_REQ requesters.
// Optional build macro ALU_SHARE_ILLEGAL_OP_EN flags op 3'b111 as reserved.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int OP_W    = DEF_OP_W
) (
    input  logic              clk,
    input  logic              rst,
    alu_share_arbiter_if.slave bus
);

    localparam int IW = $clog2(NUM_REQ);

    state_e               state_q, state_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]        gnt_idx_q, gnt_idx_d;
    logic [DATA_W-1:0]    alu_a_q, alu_a_d;
    logic [DATA_W-1:0]    alu_b_q, alu_b_d;
    logic [OP_W-1:0]      alu_op_q, alu_op_d;
    logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ-1:0]   req_ready_s;
    logic [NUM_REQ-1:0]   pick_gnt_s;
    logic [IW-1:0]        pick_idx_s;
    logic                 pick_any_s;

    alu_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req_i (bus.req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt_s),
        .idx_o (pick_idx_s),
        .any_o (pick_any_s)
    );

    // Next-state, grant and operand/result capture.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_idx_d   = gnt_idx_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        rsp_valid_d = rsp_valid_q;
        req_ready_s = '0;
        case (state_q)
            IDLE: begin
                // Grant is gated by rst so req_ready reads 0 while reset is held.
                if (pick_any_s && !rst) begin
                    req_ready_s = pick_gnt_s;
                    gnt_idx_d   = pick_idx_s;
                    alu_a_d     = bus.req_a[pick_idx_s*DATA_W +: DATA_W];
                    alu_b_d     = bus.req_b[pick_idx_s*DATA_W +: DATA_W];
                    alu_op_d    = bus.req_op[pick_idx_s*OP_W +: OP_W];
                    state_d     = EXEC;
                end else begin
                    state_d     = IDLE;
                end
            end
            EXEC: begin
`ifdef ALU_SHARE_ILLEGAL_OP_EN
                if (alu_op_q == OP_W'(ALU_RSVD)) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                end else begin
                    rsp_data_d = bus.alu_result;
                    rsp_err_d  = 1'b0;
                end
`else
                rsp_data_d  = bus.alu_result;
                rsp_err_d   = 1'b0;
`endif
                rsp_valid_d = NUM_REQ'(1) << gnt_idx_q;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.rsp_ready[gnt_idx_q]) begin
                    rsp_valid_d = '0;
                    rr_ptr_d    = (gnt_idx_q == IW'(NUM_REQ - 1)) ? '0 : gnt_idx_q + IW'(1);
                    state_d     = IDLE;
                end else begin
                    state_d     = RESP;
                end
            end
            default: begin
                rsp_valid_d = '0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            gnt_idx_q   <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_idx_q   <= gnt_idx_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign bus.req_ready   = req_ready_s;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_control = alu_op_q;
    assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with a behavioural model of the shared ALU.
module tb_alu_share_arbiter;
    import alu_share_pkg::*;

    typedef struct {
        logic [3:0]  gnt;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] a_arr  [4];
    logic [31:0] b_arr  [4];
    logic [2:0]  op_arr [4];
    exp_t        sb_q [$];
    int          n_checks;
    int          n_errors;

    alu_share_arbiter_if #(.NUM_REQ(4), .DATA_W(32), .OP_W(3)) bus ();

    alu_share_arbiter #(.NUM_REQ(4), .DATA_W(32), .OP_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            bus.req_a[i*32 +: 32] = a_arr[i];
            bus.req_b[i*32 +: 32] = b_arr[i];
            bus.req_op[i*3 +: 3]  = op_arr[i];
        end
    end

    always_comb begin
        case (bus.alu_control)
            ALU_ADD: bus.alu_result = bus.alu_a + bus.alu_b;
            ALU_SUB: bus.alu_result = bus.alu_a - bus.alu_b;
            ALU_NOT: bus.alu_result = ~bus.alu_a;
            ALU_SHL: bus.alu_result = bus.alu_a << bus.alu_b[4:0];
            ALU_SHR: bus.alu_result = bus.alu_a >> bus.alu_b[4:0];
            ALU_AND: bus.alu_result = bus.alu_a & bus.alu_b;
            ALU_OR:  bus.alu_result = bus.alu_a | bus.alu_b;
            default: bus.alu_result = bus.alu_a + bus.alu_b;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [3:0] gnt, input logic [31:0] data, input logic err);
        exp_t e;
        e.gnt  = gnt;
        e.data = data;
        e.err  = err;
        sb_q.push_back(e);
    endtask

    // Response monitor: every completed response handshake is popped and compared.
    always @(negedge clk) begin
        if (!rst && ((bus.rsp_valid & bus.rsp_ready) != 4'b0000)) begin
            if (sb_q.size() == 0) begin
                chk("rsp_unexpected", {60'd0, bus.rsp_valid}, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("rsp_gnt",  {60'd0, bus.rsp_valid}, {60'd0, e.gnt});
                chk("rsp_data", {32'd0, bus.rsp_data},  {32'd0, e.data});
                chk("rsp_err",  {63'd0, bus.rsp_err},   {63'd0, e.err});
            end
        end
    end

    task automatic wait_drain(input int max_cycles);
        for (int c = 0; c < max_cycles; c++) begin
            @(negedge clk);
            #1;
            if (sb_q.size() == 0) break;
        end
        if (sb_q.size() != 0) chk("drain_timeout", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic single_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] op, input logic [31:0] exp_d, input logic exp_e);
        logic [3:0] oh;
        oh         = 4'b0001 << idx;
        a_arr[idx] = a;
        b_arr[idx] = b;
        op_arr[idx] = op;
        push_exp(oh, exp_d, exp_e);
        bus.req_valid = oh;
        @(negedge clk);
        chk("single_grant", {60'd0, bus.req_ready}, {60'd0, oh});
        @(posedge clk); #1;
        bus.req_valid = 4'b0000;
        wait_drain(10);
        @(posedge clk); #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 4; i++) begin
            a_arr[i]  = 32'd0;
            b_arr[i]  = 32'd0;
            op_arr[i] = 3'b000;
        end
        bus.req_valid = 4'b0000;
        bus.rsp_ready = 4'b1111;
        rst = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_req_ready", {60'd0, bus.req_ready}, 64'd0);
        chk("rst_rsp_valid", {60'd0, bus.rsp_valid}, 64'd0);
        chk("rst_rsp_data",  {32'd0, bus.rsp_data},  64'd0);
        chk("rst_rsp_err",   {63'd0, bus.rsp_err},   64'd0);
        chk("rst_alu_a",     {32'd0, bus.alu_a},     64'd0);
        chk("rst_alu_b",     {32'd0, bus.alu_b},     64'd0);
        chk("rst_alu_ctl",   {61'd0, bus.alu_control}, 64'd0);
        chk("rst_busy",      {63'd0, bus.busy},      64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single request from requester 2: 5 - 3
        a_arr[2] = 32'd5; b_arr[2] = 32'd3; op_arr[2] = ALU_SUB;
        push_exp(4'b0100, 32'd2, 1'b0);
        bus.req_valid = 4'b0100;
        @(negedge clk);
        chk("t1_grant_N", {60'd0, bus.req_ready}, 64'h4);
        @(posedge clk); #1;
        bus.req_valid = 4'b0000;
        @(negedge clk);
        chk("t1_busy_N1",   {63'd0, bus.busy}, 64'd1);
        chk("t1_rvalid_N1", {60'd0, bus.rsp_valid}, 64'd0);
        chk("t1_alu_a",     {32'd0, bus.alu_a}, 64'd5);
        chk("t1_alu_b",     {32'd0, bus.alu_b}, 64'd3);
        chk("t1_alu_ctl",   {61'd0, bus.alu_control}, 64'd1);
        @(negedge clk);
        chk("t1_rvalid_N2", {60'd0, bus.rsp_valid}, 64'h4);
        @(negedge clk);
        chk("t1_idle_N3",   {63'd0, bus.busy}, 64'd0);
        chk("t1_rv_N3",     {60'd0, bus.rsp_valid}, 64'd0);
        @(posedge clk); #1;

        // All four requesters valid from reset
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_arr[i] = 32'(i); b_arr[i] = 32'd10; op_arr[i] = ALU_ADD;
        end
        bus.req_valid = 4'b1111;
        @(negedge clk);
        chk("t2_rst_ready", {60'd0, bus.req_ready}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) push_exp(4'b0001 << (k % 4), 32'(10 + (k % 4)), 1'b0);
        wait_drain(60);
        @(posedge clk); #1;
        bus.req_valid = 4'b0000;

        // Backpressure with operand change after grant
        bus.rsp_ready = 4'b0000;
        a_arr[1] = 32'd100; b_arr[1] = 32'd23;
        a_arr[0] = 32'd1;   b_arr[0] = 32'd2;
        push_exp(4'b0010, 32'd123, 1'b0);
        push_exp(4'b0001, 32'd3, 1'b0);
        bus.req_valid = 4'b0011;
        @(negedge clk);
        chk("t3_grant1", {60'd0, bus.req_ready}, 64'h2);
        @(posedge clk); #1;
        bus.req_valid = 4'b0001;
        a_arr[1] = 32'd999;
        @(negedge clk);
        chk("t3_exec_noready", {60'd0, bus.req_ready}, 64'd0);
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_bp_rvalid", {60'd0, bus.rsp_valid}, 64'h2);
            chk("t3_bp_data",   {32'd0, bus.rsp_data}, 64'd123);
            chk("t3_bp_nogrant", {60'd0, bus.req_ready}, 64'd0);
            chk("t3_bp_alu_a",  {32'd0, bus.alu_a}, 64'd100);
            @(posedge clk); #1;
            a_arr[1] = 32'(500 + k);
        end
        bus.rsp_ready = 4'b1111;
        wait_drain(20);
        @(posedge clk); #1;
        bus.req_valid = 4'b0000;

        // Reset during EXEC drops the op and clears rr_ptr
        a_arr[3] = 32'd4; b_arr[3] = 32'd4; op_arr[3] = ALU_ADD;
        bus.req_valid = 4'b1000;
        @(negedge clk);
        chk("t4_grant3", {60'd0, bus.req_ready}, 64'h8);
        @(posedge clk); #1;
        bus.req_valid = 4'b0000;
        rst = 1'b1;
        #1;
        chk("t4_rst_rvalid", {60'd0, bus.rsp_valid}, 64'd0);
        chk("t4_rst_busy",   {63'd0, bus.busy}, 64'd0);
        chk("t4_rst_alu_a",  {32'd0, bus.alu_a}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_no_rsp", {60'd0, bus.rsp_valid}, 64'd0);
        end
        @(posedge clk); #1;
        a_arr[0] = 32'd50;     b_arr[0] = 32'd8;      op_arr[0] = ALU_SUB;
        a_arr[3] = 32'hF0F0;   b_arr[3] = 32'hFF00;   op_arr[3] = ALU_AND;
        push_exp(4'b0001, 32'd42, 1'b0);
        push_exp(4'b1000, 32'hF000, 1'b0);
        bus.req_valid = 4'b1001;
        @(negedge clk);
        chk("t4_ptr_reset", {60'd0, bus.req_ready}, 64'h1);
        wait_drain(20);
        @(posedge clk); #1;
        bus.req_valid = 4'b0000;

        // Reserved op
`ifdef ALU_SHARE_ILLEGAL_OP_EN
        single_op(2, 32'd7, 32'd1, ALU_RSVD, 32'd0, 1'b1);
`else
        single_op(2, 32'd7, 32'd1, ALU_RSVD, 32'd8, 1'b0);
`endif

        // Requester 3 pulses while busy and is never granted
        a_arr[1] = 32'h0F; b_arr[1] = 32'hF0; op_arr[1] = ALU_OR;
        push_exp(4'b0010, 32'hFF, 1'b0);
        bus.req_valid = 4'b0010;
        @(negedge clk);
        chk("t6_grant1", {60'd0, bus.req_ready}, 64'h2);
        @(posedge clk); #1;
        bus.req_valid = 4'b1000;
        @(posedge clk); #1;
        bus.req_valid = 4'b0000;
        wait_drain(10);
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t6_idle_busy",  {63'd0, bus.busy}, 64'd0);
            chk("t6_idle_ready", {60'd0, bus.req_ready}, 64'd0);
        end
        @(posedge clk); #1;

        // Remaining ALU functions
        single_op(0, 32'h0000FFFF, 32'd0, ALU_NOT, 32'hFFFF0000, 1'b0);
        single_op(0, 32'd1, 32'd4, ALU_SHL, 32'd16, 1'b0);
        single_op(0, 32'h100, 32'd4, ALU_SHR, 32'h10, 1'b0);

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
